// File: rtl/uno_seq_ctrl.sv
// -----------------------------------------------------------------------------
// uno_seq_ctrl
// Sequencer for unary (div/exp/log) evaluation on the shared PE datapath.
// It takes one unary request at a time and drives the variable-generator mode
// and operand. It then steps the MAC through a Horner series, counting the
// coefficient index down, and reports completion on a valid/ready handshake.
// It never starts while GEMM owns the array. It holds mode 00 (GEMM) outside
// the LOAD/ITER/DRAIN states.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready is combinational)
//   req_op                01 div, 10 exp, 11 log, 00 illegal
//   req_x                 operand (Q5.10 signed)
//   gemm_busy_i           GEMM currently owns the array
//   gemm_uno_o, x_o       mode and operand to the variable generator
//   mac_en_o, mac_clr_o   MAC accumulate enable / accumulator clear
//   coef_idx_o            coefficient ROM index, valid while mac_en_o
//   busy_o                sequencer is not idle
//   done_valid/done_ready completion handshake, done_err flags op 00
// -----------------------------------------------------------------------------
module uno_seq_ctrl #(
  parameter int MUL_BW    = 16,
  parameter int CNT_BW    = 4,
  parameter int DIV_TERMS = 8,
  parameter int EXP_TERMS = 6,
  parameter int LOG_TERMS = 10,
  parameter int VAR_LAT   = 1,
  parameter int MAC_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [MUL_BW-1:0] req_x,
  input  logic              gemm_busy_i,
  output logic [1:0]        gemm_uno_o,
  output logic [MUL_BW-1:0] x_o,
  output logic              mac_en_o,
  output logic              mac_clr_o,
  output logic [CNT_BW-1:0] coef_idx_o,
  output logic              busy_o,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // The counter holds "cycles remaining in this state minus one" and is
  // reloaded on every state entry, so a single counter serves all phases.
  localparam logic [CNT_BW-1:0] CNT_ZERO  = {CNT_BW{1'b0}};
  localparam logic [CNT_BW-1:0] CNT_ONE   = CNT_BW'(1);
  localparam logic [CNT_BW-1:0] LOAD_CNT  = CNT_BW'(VAR_LAT);
  localparam logic [CNT_BW-1:0] DRAIN_CNT = CNT_BW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam logic [CNT_BW-1:0] DIV_LAST  = CNT_BW'(DIV_TERMS - 1);
  localparam logic [CNT_BW-1:0] EXP_LAST  = CNT_BW'(EXP_TERMS - 1);
  localparam logic [CNT_BW-1:0] LOG_LAST  = CNT_BW'(LOG_TERMS - 1);
  localparam logic [MUL_BW-1:0] X_ZERO    = {MUL_BW{1'b0}};

  state_t            state_r;
  logic [CNT_BW-1:0] cnt_r;

  // Highest coefficient index (N-1) for the latched op.
  function automatic logic [CNT_BW-1:0] last_idx(input logic [1:0] op);
    case (op)
      2'b01:   last_idx = DIV_LAST;
      2'b10:   last_idx = EXP_LAST;
      2'b11:   last_idx = LOG_LAST;
      default: last_idx = CNT_ZERO;
    endcase
  endfunction

  // GEMM wins the array whenever it is busy while we are idle.
  assign req_ready = (state_r == S_IDLE) && !gemm_busy_i;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      gemm_uno_o <= 2'b00;
      x_o        <= X_ZERO;
      mac_en_o   <= 1'b0;
      mac_clr_o  <= 1'b0;
      coef_idx_o <= CNT_ZERO;
      busy_o     <= 1'b0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            busy_o <= 1'b1;
            if (req_op == 2'b00) begin
              // An illegal op skips the datapath and only reports the error.
              state_r    <= S_DONE;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
            end else begin
              state_r    <= S_LOAD;
              cnt_r      <= LOAD_CNT;
              gemm_uno_o <= req_op;
              x_o        <= req_x;
            end
          end
        end

        S_LOAD: begin
          if (cnt_r == CNT_ZERO) begin
            // gemm_uno_o still holds the latched op here.
            state_r    <= S_ITER;
            cnt_r      <= last_idx(gemm_uno_o);
            coef_idx_o <= last_idx(gemm_uno_o);
            mac_en_o   <= 1'b1;
            mac_clr_o  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        S_ITER: begin
          mac_clr_o <= 1'b0;
          if (cnt_r == CNT_ZERO) begin
            // Stop at index 0 so the counter never wraps.
            mac_en_o   <= 1'b0;
            coef_idx_o <= CNT_ZERO;
            if (MAC_LAT > 0) begin
              state_r <= S_DRAIN;
              cnt_r   <= DRAIN_CNT;
            end else begin
              state_r    <= S_DONE;
              done_valid <= 1'b1;
              gemm_uno_o <= 2'b00;
              x_o        <= X_ZERO;
            end
          end else begin
            cnt_r      <= cnt_r - CNT_ONE;
            coef_idx_o <= cnt_r - CNT_ONE;
            mac_en_o   <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (cnt_r == CNT_ZERO) begin
            // Leaving the array: mode returns to GEMM while the result waits.
            state_r    <= S_DONE;
            done_valid <= 1'b1;
            gemm_uno_o <= 2'b00;
            x_o        <= X_ZERO;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        S_DONE: begin
          if (done_ready) begin
            state_r    <= S_IDLE;
            busy_o     <= 1'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            gemm_uno_o <= 2'b00;
            x_o        <= X_ZERO;
          end
        end

        default: begin
          state_r    <= S_IDLE;
          cnt_r      <= CNT_ZERO;
          gemm_uno_o <= 2'b00;
          x_o        <= X_ZERO;
          mac_en_o   <= 1'b0;
          mac_clr_o  <= 1'b0;
          coef_idx_o <= CNT_ZERO;
          busy_o     <= 1'b0;
          done_valid <= 1'b0;
          done_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uno_seq_ctrl.sv
// Testbench for uno_seq_ctrl: directed jobs whose expected MAC pulses and
// completion cycles go into queues, and a negedge monitor compares them.
module tb_uno_seq_ctrl;

  localparam int MAC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  // DUT 0: default parameters
  logic        req_valid, req_ready, gemm_busy, done_ready;
  logic [1:0]  req_op, gemm_uno;
  logic [15:0] req_x, x_out;
  logic        mac_en, mac_clr, busy, done_valid, done_err;
  logic [3:0]  coef_idx;

  // DUT 1: EXP_TERMS = 1
  logic        req_valid1, req_ready1, done_ready1;
  logic [1:0]  req_op1, gemm_uno1;
  logic [15:0] req_x1, x_out1;
  logic        mac_en1, mac_clr1, busy1, done_valid1, done_err1;
  logic [3:0]  coef_idx1;

  typedef struct {int cyc; logic [3:0] idx; logic clr; logic [1:0] mode; logic [15:0] x;} mac_exp_t;
  typedef struct {int cyc; logic err;} done_exp_t;
  mac_exp_t  mac_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int errors = 0;
  logic dv_prev = 1'b0;

  uno_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .gemm_busy_i(gemm_busy), .gemm_uno_o(gemm_uno),
    .x_o(x_out), .mac_en_o(mac_en), .mac_clr_o(mac_clr), .coef_idx_o(coef_idx),
    .busy_o(busy), .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err)
  );

  uno_seq_ctrl #(.EXP_TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op1), .req_x(req_x1), .gemm_busy_i(1'b0), .gemm_uno_o(gemm_uno1),
    .x_o(x_out1), .mac_en_o(mac_en1), .mac_clr_o(mac_clr1), .coef_idx_o(coef_idx1),
    .busy_o(busy1), .done_valid(done_valid1), .done_ready(done_ready1), .done_err(done_err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected MAC pulses and completions as the DUT presents them.
  always @(negedge clk) begin : monitor
    mac_exp_t  me;
    done_exp_t de;
    if (mac_en) begin
      if (mac_q.size() == 0) begin
        check("unexpected_mac_en", 32'd1, 32'd0);
      end else begin
        me = mac_q.pop_front();
        check("mac_cycle", cyc, me.cyc);
        check("coef_idx", {28'd0, coef_idx}, {28'd0, me.idx});
        check("mac_clr", {31'd0, mac_clr}, {31'd0, me.clr});
        check("iter_mode", {30'd0, gemm_uno}, {30'd0, me.mode});
        check("iter_x", {16'd0, x_out}, {16'd0, me.x});
      end
    end else if (mac_clr) begin
      check("clr_without_en", 32'd1, 32'd0);
    end
    if (!busy) begin
      check("idle_mode", {30'd0, gemm_uno}, 32'd0);
      check("idle_x", {16'd0, x_out}, 32'd0);
    end
    if (done_valid && !dv_prev) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        de = done_q.pop_front();
        check("done_cycle", cyc, de.cyc);
        check("done_err", {31'd0, done_err}, {31'd0, de.err});
      end
    end
    dv_prev <= done_valid;
  end

  // Hand-derived schedule: accept at cycle a, MAC pulses from a+3, done after MAC_LAT drain.
  task automatic push_job(input logic [1:0] op, input logic [15:0] x, input int n, input int a);
    if (op == 2'b00) begin
      done_q.push_back('{a + 1, 1'b1});
    end else begin
      for (int k = 0; k < n; k++)
        mac_q.push_back('{a + 3 + k, 4'(n - 1 - k), (k == 0), op, x});
      done_q.push_back('{a + 3 + n + MAC_LAT, 1'b0});
    end
  endtask

  task automatic run_job(input logic [1:0] op, input logic [15:0] x, input int n,
                         input int stall, input bit busy_after, output int acc, output int hs);
    acc = -1;
    hs  = -1;
    req_op = op; req_x = x; req_valid = 1'b1; done_ready = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin acc = cyc; break; end
      @(negedge clk); #1;
    end
    if (acc < 0) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    push_job(op, x, n, acc);
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b01; req_x = 16'hDEAD;
    check("busy_c1", {31'd0, busy}, 32'd1);
    check("mode_c1", {30'd0, gemm_uno}, {30'd0, op});
    check("x_c1", {16'd0, x_out}, (op == 2'b00) ? 32'd0 : {16'd0, x});
    if (busy_after) gemm_busy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done_valid) break;
      @(negedge clk);
    end
    if (!done_valid) begin
      check("done_timeout", 32'd0, 32'd1);
      gemm_busy = 1'b0;
      return;
    end
    for (int s = 0; s < stall; s++) begin
      check("done_hold", {31'd0, done_valid}, 32'd1);
      @(negedge clk);
    end
    check("done_hold_hs", {31'd0, done_valid}, 32'd1);
    done_ready = 1'b1;
    hs = cyc;
    @(negedge clk);
    done_ready = 1'b0;
    gemm_busy  = 1'b0;
    check("done_cleared", {31'd0, done_valid}, 32'd0);
    check("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a, hs, a2, hs2, t0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_x = 16'h0000; gemm_busy = 1'b0; done_ready = 1'b0;
    req_valid1 = 1'b0; req_op1 = 2'b00; req_x1 = 16'h0000; done_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mode", {30'd0, gemm_uno}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done_valid}, 32'd0);
    check("rst_mac", {31'd0, mac_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. div
    run_job(2'b01, 16'h0600, 8, 0, 1'b0, a, hs);
    // 2. exp with a 3-cycle stall, then log back to back
    run_job(2'b10, 16'h0200, 6, 3, 1'b0, a, hs);
    run_job(2'b11, 16'h0400, 10, 0, 1'b0, a2, hs2);
    check("b2b_accept", a2, hs + 1);
    // 3. GEMM busy blocks acceptance for 5 cycles; busy after accept is ignored
    gemm_busy = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_x = 16'h0123;
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("gemm_blocks", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    gemm_busy = 1'b0;
    run_job(2'b01, 16'h0123, 8, 0, 1'b1, a, hs);
    check("gemm_accept_cycle", a, t0 + 5);
    // 4. illegal op
    run_job(2'b00, 16'h1234, 0, 0, 1'b0, a, hs);
    // 5. reset in cycle 6 of a div job
    req_op = 2'b01; req_x = 16'h0600; req_valid = 1'b1;
    #1;
    a = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin a = cyc; break; end
      @(negedge clk); #1;
    end
    check("rst_job_accept", {31'd0, (a >= 0)}, 32'd1);
    push_job(2'b01, 16'h0600, 8, a);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cyc == a + 6) break;
    end
    rst_n = 1'b0;
    #1;
    check("abort_mode", {30'd0, gemm_uno}, 32'd0);
    check("abort_x", {16'd0, x_out}, 32'd0);
    check("abort_mac_en", {31'd0, mac_en}, 32'd0);
    check("abort_idx", {28'd0, coef_idx}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done_valid}, 32'd0);
    check("abort_pending_mac", mac_q.size(), 32'd5);
    mac_q.delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(2'b01, 16'h0600, 8, 0, 1'b0, a, hs);
    // 6. EXP_TERMS = 1 build
    req_op1 = 2'b10; req_x1 = 16'h0100; req_valid1 = 1'b1;
    #1;
    check("n1_ready", {31'd0, req_ready1}, 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_valid1 = 1'b0;
      check("n1_mac_en", {31'd0, mac_en1}, {31'd0, (k == 3)});
      check("n1_mac_clr", {31'd0, mac_clr1}, {31'd0, (k == 3)});
      if (k == 3) check("n1_idx", {28'd0, coef_idx1}, 32'd0);
      check("n1_done", {31'd0, done_valid1}, {31'd0, (k == 6)});
      check("n1_mode", {30'd0, gemm_uno1}, (k <= 5) ? 32'd2 : 32'd0);
    end

    repeat (2) @(negedge clk);
    check("mac_q_empty", mac_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
